// File: rtl/mod_mul.sv
// rtl/mod_mul.sv - interleaved MSB-first modular multiplier, product = x*y mod P.
// Optional MOD_MUL_INPUT_REDUCE_EN adds a one-cycle REDUCE state so operands in [0, 2^WIDTH) are accepted.
module mod_mul #(
   parameter int               WIDTH = 256,
   parameter logic [WIDTH-1:0] P     = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH+1:0] P_E = {2'b00, P};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DONE   = 2'd2
`ifdef MOD_MUL_INPUT_REDUCE_EN
      ,
      REDUCE = 2'd3
`endif
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] x_reg, x_n;
   logic [WIDTH-1:0] y_reg, y_n;
   logic [WIDTH-1:0] acc, acc_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] product_n;

   logic [WIDTH+1:0] dbl;
   logic [WIDTH-1:0] dbl_r;
   logic [WIDTH+1:0] sum;
   logic [WIDTH-1:0] sum_r;

   // One interleaved step: acc <- (2*acc mod P + y[i]*x) mod P. Both partial
   // results stay below 2P, so a single conditional subtract suffices; the low
   // WIDTH bits of the subtraction are exact because the result is < P.
   always_comb begin
      dbl   = {1'b0, acc, 1'b0};
      dbl_r = (dbl >= P_E) ? (dbl[WIDTH-1:0] - P) : dbl[WIDTH-1:0];
      sum   = {2'b00, dbl_r} + (y_reg[cnt] ? {2'b00, x_reg} : '0);
      sum_r = (sum >= P_E) ? (sum[WIDTH-1:0] - P) : sum[WIDTH-1:0];
   end

   always_comb begin
      state_n   = state;
      x_n       = x_reg;
      y_n       = y_reg;
      acc_n     = acc;
      cnt_n     = cnt;
      product_n = product;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               x_n   = x;
               y_n   = y;
               acc_n = '0;
               cnt_n = CW'(WIDTH - 1);
`ifdef MOD_MUL_INPUT_REDUCE_EN
               state_n = REDUCE;
`else
               state_n = RUN;
`endif
            end
         end
`ifdef MOD_MUL_INPUT_REDUCE_EN
         REDUCE: begin
            busy    = 1'b1;
            x_n     = (x_reg >= P) ? (x_reg - P) : x_reg;
            y_n     = (y_reg >= P) ? (y_reg - P) : y_reg;
            state_n = RUN;
         end
`endif
         RUN: begin
            busy  = 1'b1;
            acc_n = sum_r;
            if (cnt == '0) begin
               product_n = sum_r;
               state_n   = DONE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               x_n   = x;
               y_n   = y;
               acc_n = '0;
               cnt_n = CW'(WIDTH - 1);
`ifdef MOD_MUL_INPUT_REDUCE_EN
               state_n = REDUCE;
`else
               state_n = RUN;
`endif
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         x_reg   <= '0;
         y_reg   <= '0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         state   <= state_n;
         x_reg   <= x_n;
         y_reg   <= y_n;
         acc     <= acc_n;
         cnt     <= cnt_n;
         product <= product_n;
      end
   end

endmodule

// File: tb/tb_mod_mul.sv
// tb/tb_mod_mul.sv - scoreboard testbench for mod_mul (secp256k1 field).
module tb_mod_mul;

   localparam int               W = 256;
   localparam logic [W-1:0]     P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
`ifdef MOD_MUL_INPUT_REDUCE_EN
   localparam int LAT = 258;
`else
   localparam int LAT = 257;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         busy;
   logic         done;
   logic [W-1:0] product;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] sb[$];

   mod_mul #(.WIDTH(W), .P(P)) dut (
      .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
      .busy(busy), .done(done), .product(product)
   );

   always #5 clk = ~clk;

   // Drive start for one edge; returns at the negedge of cycle 1 of the operation.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e);
      x     = a;
      y     = b;
      start = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int n0, output int n, output bit busy_ok);
      n       = n0;
      busy_ok = 1'b1;
      while (!done && n < 400) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0;
      x     = '0;
      y     = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b product=%h required 0 0 0", busy, done, product);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e);
      int n;
      bit bok;
      logic [W-1:0] exp;
      issue(a, b, e);
      wait_done(1, n, bok);
      exp = sb.pop_front();
      checks++;
      if (n !== LAT) begin
         errors++;
         $display("FAIL %s_latency: got %0d cycles required %0d", name, n, LAT);
      end
      checks++;
      if (!bok || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy: busy during run ok=%b busy at done=%b required 1 0", name, bok, busy);
      end
      checks++;
      if (product !== exp) begin
         errors++;
         $display("FAIL %s_product: got %h required %h", name, product, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_basic;
      run_one("basic_2x3", 256'd2, 256'd3, 256'd6);
   endtask

   task automatic test_edges;
      logic [W-1:0] a;
      a = 256'hA3F9D2B8C6A1F4E2B3A7D1E4F123CB98A1234567890ABCDEFA1234567890F12;
      run_one("pm1_sq", P - 1, P - 1, 256'd1);
      run_one("2p128_sq", 256'd1 << 128, 256'd1 << 128, 256'h1000003D1);
      run_one("a_times_1", a, 256'd1, a);
      run_one("a_times_0", a, 256'd0, 256'd0);
      run_one("zero_times_a", 256'd0, a, 256'd0);
   endtask

   task automatic test_back_to_back;
      int n;
      bit bok;
      logic [W-1:0] exp;
      issue(256'd7, 256'd9, 256'd63);
      wait_done(1, n, bok);
      exp = sb.pop_front();
      checks++;
      if (product !== exp || n !== LAT) begin
         errors++;
         $display("FAIL b2b_first: product %h at %0d required %h at %0d", product, n, exp, LAT);
      end
      issue(256'd5, 256'd5, 256'd25);
      checks++;
      if (busy !== 1'b1 || product !== 256'd63) begin
         errors++;
         $display("FAIL b2b_no_bubble: busy=%b product=%h required 1 %h", busy, product, 256'd63);
      end
      repeat (48) @(negedge clk);
      x     = 256'd1;
      y     = 256'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(50, n, bok);
      exp = sb.pop_front();
      checks++;
      if (product !== exp || n !== LAT) begin
         errors++;
         $display("FAIL b2b_second: product %h at %0d required %h at %0d", product, n, exp, LAT);
      end
      @(negedge clk);
   endtask

   task automatic test_abort;
      int  seen_done;
      int  seen_busy;
      x     = 256'd3;
      y     = 256'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (99) @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
         errors++;
         $display("FAIL abort_state: busy=%b done=%b product=%h required 0 0 0", busy, done, product);
      end
      seen_done = 0;
      seen_busy = 0;
      for (int i = 0; i < 300; i++) begin
         if (done === 1'b1) seen_done++;
         if (busy === 1'b1) seen_busy++;
         @(negedge clk);
      end
      checks++;
      if (seen_done != 0 || seen_busy != 0) begin
         errors++;
         $display("FAIL abort_quiet: done cycles %0d busy cycles %0d required 0 0", seen_done, seen_busy);
      end
      run_one("after_abort_11x13", 256'd11, 256'd13, 256'd143);
   endtask

   task automatic test_reduce;
`ifdef MOD_MUL_INPUT_REDUCE_EN
      run_one("reduce_pp5", P + 256'd5, 256'd1, 256'd5);
`else
      run_one("reduce_5", 256'd5, 256'd1, 256'd5);
`endif
   endtask

   initial begin
      test_reset;
      test_basic;
      test_edges;
      test_back_to_back;
      test_abort;
      test_reduce;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
